// File: rtl/cavlc_pkg.sv
// Shared definitions for the CAVLC coefficient statistics block.
//   RES_WIDTH        default signed residual coefficient width
//   BLK_DC/AC/4x4    legal block lengths (chroma DC, AC, full 4x4)
//   state_t          scan controller state encoding
//   eff_block_len()  maps any block_len onto a legal length (unknown -> 16)
package cavlc_pkg;

  localparam int RES_WIDTH = 16;

  localparam logic [4:0] BLK_DC  = 5'd4;
  localparam logic [4:0] BLK_AC  = 5'd15;
  localparam logic [4:0] BLK_4x4 = 5'd16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [4:0] eff_block_len(input logic [4:0] len);
    logic [4:0] eff;
    case (len)
      BLK_DC, BLK_AC, BLK_4x4: eff = len;
      default:                 eff = BLK_4x4;
    endcase
    return eff;
  endfunction

endpackage

// File: rtl/cavlc_lane_classify.sv
// Combinational classifier for one residual coefficient lane.
//   coeff  signed coefficient (two's complement, RES_WIDTH bits)
//   nz     coefficient is nonzero
//   one    coefficient is +1 or -1
//   neg    sign bit of the coefficient (1 = negative)
module cavlc_lane_classify #(
  parameter int RES_WIDTH = 16
) (
  input  logic [RES_WIDTH-1:0] coeff,
  output logic                 nz,
  output logic                 one,
  output logic                 neg
);

  localparam logic [RES_WIDTH-1:0] PLUS_ONE = {{(RES_WIDTH-1){1'b0}}, 1'b1};

  assign nz  = |coeff;
  // -1 is the all-ones pattern in two's complement.
  assign one = (coeff == PLUS_ONE) || (&coeff);
  assign neg = coeff[RES_WIDTH-1];

endmodule

// File: rtl/cavlc_coeff_stats.sv
// CAVLC coefficient statistics for one residual block.
// Coefficients arrive LANES per beat in reverse zig-zag order; at the end of
// the block the totals are registered and done pulses for one cycle.
//   clk, rst_n    clock, asynchronous active-low reset
//   start         begin a block scan (sampled in IDLE only)
//   block_len     coefficient count 4/15/16, latched with start (others -> 16)
//   coeff_vld     beat qualifier; low in SCAN stalls the scan
//   coeff_data    LANES coefficients, lane 0 (LSBs) first in scan order
//   busy          high while scanning
//   done          one-cycle pulse when results update
//   total_coeff   nonzero coefficient count
//   trail_ones    trailing +-1 count, saturated at 3
//   t1_signs      signs of the first three trailing ones (1 = negative)
//   total_zeros   zeros following the first nonzero in scan order
// LANES must be 1, 2 or 4.
module cavlc_coeff_stats #(
  parameter int RES_WIDTH = cavlc_pkg::RES_WIDTH,
  parameter int LANES     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [4:0]                   block_len,
  input  logic                         coeff_vld,
  input  logic [LANES*RES_WIDTH-1:0]   coeff_data,
  output logic                         busy,
  output logic                         done,
  output logic [4:0]                   total_coeff,
  output logic [1:0]                   trail_ones,
  output logic [2:0]                   t1_signs,
  output logic [4:0]                   total_zeros
);

  import cavlc_pkg::*;

  state_t state_q, state_n;

  logic [4:0] len_q;        // effective block length
  logic [4:0] last_beat_q;  // index of the final beat of this block
  logic [4:0] beat_q;

  logic [4:0] nz_q,    nz_n;
  logic [4:0] zeros_q, zeros_n;
  logic [1:0] t1_q,    t1_n;
  logic [2:0] signs_q, signs_n;
  logic       chain_q, chain_n;  // trailing-ones chain still open
  logic       seen_q,  seen_n;   // a nonzero has been seen this block

  logic [LANES-1:0] lane_nz, lane_one, lane_neg;
  logic             last_beat;
  logic             accept;

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      cavlc_lane_classify #(.RES_WIDTH(RES_WIDTH)) u_classify (
        .coeff (coeff_data[g*RES_WIDTH +: RES_WIDTH]),
        .nz    (lane_nz[g]),
        .one   (lane_one[g]),
        .neg   (lane_neg[g])
      );
    end
  endgenerate

  assign last_beat = (beat_q == last_beat_q);
  assign accept    = (state_q == SCAN) && coeff_vld;
  assign busy      = (state_q == SCAN);
  assign done      = (state_q == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (start) state_n = SCAN;
      SCAN:    if (coeff_vld && last_beat) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Lane chain for the current beat. Lanes are walked in scan order so that a
  // large coefficient in lane 0 closes the trailing-ones chain for lane 1.
  logic [6:0] lane_idx;
  logic [2:0] t1_wide;

  always_comb begin
    nz_n     = nz_q;
    zeros_n  = zeros_q;
    t1_n     = t1_q;
    signs_n  = signs_q;
    chain_n  = chain_q;
    seen_n   = seen_q;
    lane_idx = '0;
    t1_wide  = '0;
    // NOTE: blocking assignments here are deliberate: each lane iteration
    // must see the updates made by the lanes before it within the same beat.
    for (int l = 0; l < LANES; l++) begin
      lane_idx = 7'(beat_q) * 7'(LANES) + 7'(l);
      if (lane_idx < 7'(len_q)) begin
        if (lane_nz[l]) begin
          nz_n   = nz_n + 5'd1;
          seen_n = 1'b1;
          if (chain_n) begin
            if (lane_one[l]) begin
              case (t1_n)
                2'd0:    signs_n[0] = lane_neg[l];
                2'd1:    signs_n[1] = lane_neg[l];
                2'd2:    signs_n[2] = lane_neg[l];
                default: ;
              endcase
              t1_wide = {1'b0, t1_n} + 3'd1;
              t1_n    = (t1_wide > 3'd3) ? 2'd3 : t1_wide[1:0];
            end else begin
              chain_n = 1'b0;
            end
          end
        end else if (seen_n) begin
          zeros_n = zeros_n + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      last_beat_q <= '0;
      beat_q      <= '0;
      nz_q        <= '0;
      zeros_q     <= '0;
      t1_q        <= '0;
      signs_q     <= '0;
      chain_q     <= 1'b0;
      seen_q      <= 1'b0;
      total_coeff <= '0;
      trail_ones  <= '0;
      t1_signs    <= '0;
      total_zeros <= '0;
    end else begin
      if ((state_q == IDLE) && start) begin
        len_q       <= eff_block_len(block_len);
        last_beat_q <= 5'((int'(eff_block_len(block_len)) + LANES - 1) / LANES - 1);
        beat_q      <= '0;
        nz_q        <= '0;
        zeros_q     <= '0;
        t1_q        <= '0;
        signs_q     <= '0;
        chain_q     <= 1'b1;
        seen_q      <= 1'b0;
      end else if (accept) begin
        beat_q  <= beat_q + 5'd1;
        nz_q    <= nz_n;
        zeros_q <= zeros_n;
        t1_q    <= t1_n;
        signs_q <= signs_n;
        chain_q <= chain_n;
        seen_q  <= seen_n;
        if (last_beat) begin
          total_coeff <= nz_n;
          trail_ones  <= t1_n;
          t1_signs    <= signs_n;
          total_zeros <= zeros_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_cavlc_coeff_stats.sv
// Scoreboard bench for cavlc_coeff_stats: the driver loads a block, pushes the
// reference result and expected done cycle, then drives beats; a monitor pops
// and compares on every done pulse and checks that outputs hold otherwise.
module tb_cavlc_coeff_stats;

  localparam int RW    = 16;
  localparam int LANES = 2;

  typedef struct {
    logic [4:0] tc;
    logic [1:0] t1;
    logic [2:0] sg;
    logic [4:0] tz;
    int         done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   cur[64];

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [4:0]            block_len = '0;
  logic                  coeff_vld = 1'b0;
  logic [LANES*RW-1:0]   coeff_data = '0;
  logic                  busy, done;
  logic [4:0]            total_coeff, total_zeros;
  logic [1:0]            trail_ones;
  logic [2:0]            t1_signs;

  cavlc_coeff_stats #(.RES_WIDTH(RW), .LANES(LANES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .block_len   (block_len),
    .coeff_vld   (coeff_vld),
    .coeff_data  (coeff_data),
    .busy        (busy),
    .done        (done),
    .total_coeff (total_coeff),
    .trail_ones  (trail_ones),
    .t1_signs    (t1_signs),
    .total_zeros (total_zeros)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: statistics straight from the definitions, over the scan list.
  function automatic exp_t model(input int len_eff);
    exp_t e;
    int   first, k;
    e.tc = '0; e.t1 = '0; e.sg = '0; e.tz = '0; e.done_cyc = 0;
    first = -1;
    for (int i = 0; i < len_eff; i++)
      if (cur[i] != 0) begin
        e.tc++;
        if (first < 0) first = i;
      end
    if (first >= 0)
      for (int i = first; i < len_eff; i++)
        if (cur[i] == 0) e.tz++;
    // +-1 values before the first larger-magnitude nonzero are trailing ones.
    k = 0;
    for (int i = 0; i < len_eff; i++) begin
      if (cur[i] == 0) continue;
      if (cur[i] == 1 || cur[i] == -1) begin
        if (k < 3) e.sg[k] = (cur[i] < 0);
        k++;
      end else break;
    end
    e.t1 = (k > 3) ? 2'd3 : 2'(k);
    return e;
  endfunction

  function automatic int rnd_coef();
    int r;
    logic signed [RW-1:0] v;
    r = $urandom_range(0, 99);
    if (r < 40) return 0;
    if (r < 65) return ($urandom_range(0, 1) != 0) ? 1 : -1;
    v = RW'($urandom);
    return int'(v);
  endfunction

  function automatic int rnd_raw();
    logic signed [RW-1:0] v;
    v = RW'($urandom);
    return int'(v);
  endfunction

  // Runs one block from cur[]. abort_after >= 0 pulses reset before that beat.
  task automatic run_block(input logic [4:0] len, input int n_stall,
                           input bit poke_start, input int abort_after);
    int   len_eff, beats, s_cyc;
    int   stall_before[64];
    exp_t e;
    len_eff = (len == 5'd4 || len == 5'd15 || len == 5'd16) ? int'(len) : 16;
    beats   = (len_eff + LANES - 1) / LANES;
    for (int i = 0; i < 64; i++) stall_before[i] = 0;
    for (int k = 0; k < n_stall; k++) stall_before[$urandom_range(0, beats - 1)]++;

    @(posedge clk); #1;
    start     = 1'b1;
    block_len = len;
    s_cyc     = cyc;
    if (abort_after < 0) begin
      e = model(len_eff);
      e.done_cyc = s_cyc + 1 + beats + n_stall;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    start     = 1'b0;
    block_len = 5'($urandom);

    for (int b = 0; b < beats; b++) begin
      if (b == abort_after) begin
        rst_n     = 1'b0;
        coeff_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      for (int s = 0; s < stall_before[b]; s++) begin
        coeff_vld  = 1'b0;
        coeff_data = {$urandom, $urandom};
        start      = 1'b0;
        @(posedge clk); #1;
      end
      coeff_vld = 1'b1;
      for (int l = 0; l < LANES; l++) coeff_data[l*RW +: RW] = RW'(cur[b*LANES + l]);
      if (poke_start && b == beats / 2) begin
        start     = 1'b1;
        block_len = 5'd4;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    coeff_vld  = 1'b0;
    coeff_data = {$urandom, $urandom};
    start      = poke_start;  // lands in DONE, must be ignored
    block_len  = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load_req033();
    int v[16] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, -1, 0, 0, -1, 3, 0, 0};
    for (int i = 0; i < 64; i++) cur[i] = (i < 16) ? v[i] : rnd_raw();
  endtask

  // Monitor: compare on done, otherwise outputs must hold their last value.
  initial begin
    exp_t e, hold;
    hold.tc = '0; hold.t1 = '0; hold.sg = '0; hold.tz = '0; hold.done_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold.tc = '0; hold.t1 = '0; hold.sg = '0; hold.tz = '0;
        check("reset_outputs", {busy, done, total_coeff, trail_ones, t1_signs, total_zeros}, 32'd0);
      end else if (done) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pending block (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("total_coeff", total_coeff, e.tc);
          check("trail_ones",  trail_ones,  e.t1);
          check("t1_signs",    t1_signs,    e.sg);
          check("total_zeros", total_zeros, e.tz);
          check("done_cycle",  cyc,         e.done_cyc);
          check("busy_at_done", busy, 1'b0);
          hold = e;
        end
      end else begin
        check("outputs_hold", {total_coeff, trail_ones, t1_signs, total_zeros},
              {hold.tc, hold.t1, hold.sg, hold.tz});
      end
    end
  end

  initial begin
    int   r, len, abort_at;
    logic [4:0] lsel;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reverse sequence with mixed trailing ones, then the same with stalls.
    load_req033(); run_block(5'd16, 0, 1'b0, -1);
    load_req033(); run_block(5'd16, 3, 1'b0, -1);

    // len 15: first beat {-1,2}, ignored lane 1 of the last beat holds 7.
    for (int i = 0; i < 64; i++) cur[i] = 0;
    cur[0] = -1; cur[1] = 2; cur[15] = 7;
    run_block(5'd15, 0, 1'b0, -1);

    // Chroma DC, all zero.
    for (int i = 0; i < 64; i++) cur[i] = 0;
    run_block(5'd4, 0, 1'b0, -1);

    // Abort after 4 beats, then a full block of +-1.
    for (int i = 0; i < 64; i++) cur[i] = rnd_coef();
    run_block(5'd16, 0, 1'b0, 4);
    for (int i = 0; i < 64; i++) cur[i] = ($urandom_range(0, 1) != 0) ? 1 : -1;
    run_block(5'd16, 0, 1'b0, -1);

    // start pulsed during SCAN and DONE.
    load_req033(); run_block(5'd16, 1, 1'b1, -1);

    // Illegal lengths fall back to 16.
    for (int i = 0; i < 64; i++) cur[i] = rnd_coef();
    run_block(5'd9, 0, 1'b0, -1);
    for (int i = 0; i < 64; i++) cur[i] = rnd_coef();
    run_block(5'd0, 2, 1'b0, -1);

    // Randomized blocks.
    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 3);
      lsel = (r == 0) ? 5'd4 : (r == 1) ? 5'd15 : (r == 2) ? 5'd16 : 5'($urandom_range(0, 31));
      len = (lsel == 5'd4 || lsel == 5'd15 || lsel == 5'd16) ? int'(lsel) : 16;
      for (int i = 0; i < 64; i++) cur[i] = (i < len) ? rnd_coef() : rnd_raw();
      abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, (len + LANES - 1) / LANES - 1)) : -1;
      run_block(lsel, $urandom_range(0, 3), $urandom_range(0, 3) == 0, abort_at);
    end

    for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(posedge clk);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
